tmr_scrub_engine: RTL

//  Background scrubber for a triple-modular-redundant (TMR) SRAM; sits upstream of the bit-flip rate monitor.

---
 rtl/tmr_scrub_pkg.sv | 7 +
 rtl/tmr_scrub_engine_if.sv | 9 +
 rtl/counter.sv | 13 +
 rtl/tmr_voter.sv | 13 +
 rtl/tmr_scrub_engine.sv | 84 ++++++++
 5 files changed

// File: rtl/tmr_scrub_pkg.sv
// tmr_scrub_pkg: scrub engine FSM state type and the per-bit TMR majority helper.
package tmr_scrub_pkg;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, VOTE, WR_REQ, NEXT, WAIT} scrub_state_t;
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/tmr_scrub_engine_if.sv
// tmr_scrub_engine_if: request/grant port between the scrub engine and the TMR SRAM arbiter.
interface tmr_scrub_engine_if #(parameter int DEPTH = 800, parameter int WORD_WIDTH = 32);
    localparam int AW = $clog2(DEPTH);
    logic                    req, we, gnt, rvalid;
    logic [AW-1:0]           addr;
    logic [3*WORD_WIDTH-1:0] wdata, rdata;
    modport master(output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave(input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/counter.sv
// counter: up-counter with synchronous clear taking priority over enable.
module counter #(parameter int WIDTH = 8) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) count <= '0;
        else if (clear) count <= '0;
        else if (enable) count <= count + 1'b1;
endmodule

// File: rtl/tmr_voter.sv
// tmr_voter: bitwise majority of three copies plus a flag when any copy disagrees with the vote.
module tmr_voter import tmr_scrub_pkg::*; #(parameter int WORD_WIDTH = 32) (
    input  logic [3*WORD_WIDTH-1:0] copies,
    output logic [WORD_WIDTH-1:0]   voted,
    output logic                    mismatch
);
    logic [WORD_WIDTH-1:0] c0, c1, c2;
    assign {c2, c1, c0} = copies;
    for (genvar i = 0; i < WORD_WIDTH; i++) begin : g_bit
        assign voted[i] = majority3(c0[i], c1[i], c2[i]);
    end
    assign mismatch = (c0 != voted) || (c1 != voted) || (c2 != voted);
endmodule

// File: rtl/tmr_scrub_engine.sv
// tmr_scrub_engine: background TMR SRAM scrubber; votes every word, writes back on disagreement
// and pulses the owning region's scrub_o bit for the downstream flip-rate monitor.
module tmr_scrub_engine import tmr_scrub_pkg::*; #(
    parameter int NUM_REGIONS    = 100,
    parameter int DEPTH          = 800,
    parameter int WORD_WIDTH     = 32,
    parameter int SCRUB_INTERVAL = 1024
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   enable_i,
    tmr_scrub_engine_if.master     mem,
    output logic [NUM_REGIONS-1:0] scrub_o,
    output logic                   pass_done_o,
    output logic                   busy_o
);
    localparam int AW          = $clog2(DEPTH);
    localparam int RW          = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1;
    localparam int REGION_SIZE = DEPTH / NUM_REGIONS;
    localparam int CW          = SCRUB_INTERVAL > 0 ? $clog2(SCRUB_INTERVAL + 1) : 1;

    if (DEPTH % NUM_REGIONS != 0) begin : g_bad_depth
        $error("tmr_scrub_engine: DEPTH must be a multiple of NUM_REGIONS");
    end

    scrub_state_t            state, state_nxt;
    logic [AW-1:0]           addr;
    logic [3*WORD_WIDTH-1:0] rdata_q;
    logic [WORD_WIDTH-1:0]   voted;
    logic                    mismatch, last_word, interval_done;
    logic [CW-1:0]           interval_cnt;
    logic [RW-1:0]           region;

    tmr_voter #(.WORD_WIDTH(WORD_WIDTH)) u_voter (.copies(rdata_q), .voted(voted), .mismatch(mismatch));

    // Counter only runs while waiting, so leaving WAIT for any reason restarts the interval.
    counter #(.WIDTH(CW)) u_interval (
        .clk_i(clk_i), .rstn_i(rstn_i), .clear(state != WAIT), .enable(state == WAIT), .count(interval_cnt)
    );

    assign last_word     = addr == AW'(DEPTH - 1);
    assign interval_done = interval_cnt == CW'(SCRUB_INTERVAL - 1);
    assign region        = RW'(addr / AW'(REGION_SIZE));

    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable_i) state_nxt = RD_REQ;
            RD_REQ:  if (mem.gnt) state_nxt = RD_WAIT;
            RD_WAIT: if (mem.rvalid) state_nxt = VOTE;
            VOTE:    state_nxt = mismatch ? WR_REQ : NEXT;
            WR_REQ:  if (mem.gnt) state_nxt = NEXT;
            NEXT:    state_nxt = !enable_i ? IDLE : (!last_word || SCRUB_INTERVAL == 0) ? RD_REQ : WAIT;
            WAIT:    state_nxt = !enable_i ? IDLE : interval_done ? RD_REQ : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem.req   = state == RD_REQ || state == WR_REQ;
        mem.we    = state == WR_REQ;
        mem.addr  = addr;
        mem.wdata = state == WR_REQ ? {3{voted}} : '0;
        busy_o    = state != IDLE && state != WAIT;
    end

    // rdata_q only changes in RD_WAIT, so the vote and wdata stay frozen through WR_REQ.
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            addr        <= '0;
            rdata_q     <= '0;
            scrub_o     <= '0;
            pass_done_o <= 1'b0;
        end else begin
            if (state == RD_WAIT && mem.rvalid) rdata_q <= mem.rdata;
            if (state == NEXT) addr <= (last_word || !enable_i) ? '0 : addr + 1'b1;
            scrub_o     <= (state == WR_REQ && mem.gnt) ? NUM_REGIONS'(1) << region : '0;
            pass_done_o <= state == NEXT && last_word;
        end
endmodule
